// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per cycle, fixed SIZE+1 cycle latency.
// Signed (RV32M DIV/REM) support is built only when DIVIDER_SIGNED_EN is defined.
module divider #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            isSigned,
    input  logic [SIZE-1:0] operandA,
    input  logic [SIZE-1:0] operandB,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] dvd_q, dvd_d;
    logic [SIZE-1:0] div_q, div_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] rmd_q, rmd_d;
    logic            bzero_q, bzero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SIZE:0]   shifted;
    logic [SIZE-1:0] a_mag, b_mag, q_fix, r_fix;
`ifdef DIVIDER_SIGNED_EN
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
`else
    logic            unused_signed_c;
    assign unused_signed_c = isSigned;
`endif

    // Next-state, datapath step and result correction
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        rem_d   = rem_q;
        a_d     = a_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        bzero_d = bzero_q;
        done_d  = 1'b0;
        shifted = {rem_q, dvd_q[SIZE-1]};
        a_mag   = operandA;
        b_mag   = operandB;
        q_fix   = dvd_q;
        r_fix   = rem_q;
`ifdef DIVIDER_SIGNED_EN
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (isSigned && operandA[SIZE-1]) a_mag = ~operandA + SIZE'(1);
        if (isSigned && operandB[SIZE-1]) b_mag = ~operandB + SIZE'(1);
        if (q_neg_q) q_fix = ~dvd_q + SIZE'(1);
        if (r_neg_q) r_fix = ~rem_q + SIZE'(1);
`endif
        // Divide-by-zero bypasses sign correction so the remainder is the raw dividend
        if (bzero_q) begin
            q_fix = '1;
            r_fix = a_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = operandA;
                    dvd_d   = a_mag;
                    div_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    bzero_d = (operandB == '0);
`ifdef DIVIDER_SIGNED_EN
                    q_neg_d = isSigned && (operandA[SIZE-1] ^ operandB[SIZE-1]);
                    r_neg_d = isSigned && operandA[SIZE-1];
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                if (shifted >= {1'b0, div_q}) begin
                    rem_d = SIZE'(shifted - {1'b0, div_q});
                    dvd_d = {dvd_q[SIZE-2:0], 1'b1};
                end else begin
                    rem_d = shifted[SIZE-1:0];
                    dvd_d = {dvd_q[SIZE-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SIZE - 1)) state_d = FIX;
            end
            FIX: begin
                quo_d   = q_fix;
                rmd_d   = r_fix;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            bzero_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            bzero_q <= bzero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule
